// File: rtl/triangle_assembler.sv
// Triangle assembler: caches one object's vertices, then walks an index ROM and streams
// NUM_TRI triangles as three corners each over valid/ready; IDX_LAT+4 cycles per triangle minimum.
module triangle_assembler #(
  parameter int NUM_VERT = 8,
  parameter int NUM_TRI  = 12,
  parameter int IDX_W    = 8,
  parameter int IDX_LAT  = 2
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [3:0][31:0]           vert_in,
  input  logic                       valid_in,
  input  logic                       obj_done_in,
  output logic [$clog2(NUM_TRI)-1:0] idx_addr_out,
  input  logic [3*IDX_W-1:0]         idx_data_in,
  output logic [3:0][31:0]           tri_vert_out,
  output logic [1:0]                 tri_corner_out,
  output logic                       tri_valid_out,
  input  logic                       tri_ready_in,
  output logic                       tri_last_out,
  output logic                       done_out,
  output logic [1:0]                 err_out
);
  localparam int VA_W  = (NUM_VERT > 1) ? $clog2(NUM_VERT) : 1;
  localparam int CNT_W = $clog2(NUM_VERT + 1);
  localparam int TRI_W = $clog2(NUM_TRI);
  localparam int LAT_W = (IDX_LAT > 0) ? $clog2(IDX_LAT + 1) : 1;

  typedef logic [3:0][31:0] vert_t;
  typedef enum logic [1:0] {LOAD = 2'd0, FETCH = 2'd1, EMIT = 2'd2} state_t;

  state_t                state, state_nxt;
  vert_t                 cache [NUM_VERT];
  logic [CNT_W-1:0]      wr_ptr, vcount;
  logic [TRI_W-1:0]      tri_cnt;
  logic [1:0]            corner;
  logic [LAT_W-1:0]      lat_cnt;
  logic [2:0][IDX_W-1:0] idx;
  logic [1:0]            err;

  logic             wr_en, load_exit, capture, emitting, handshake, next_tri, finish;
  logic             last_tri, out_of_range;
  logic [IDX_W-1:0] cur_idx;

  assign last_tri = (tri_cnt == TRI_W'(NUM_TRI - 1));

  always_comb begin
    cur_idx = idx[0];
    case (corner)
      2'd1:    cur_idx = idx[1];
      2'd2:    cur_idx = idx[2];
      default: cur_idx = idx[0];
    endcase
  end

  // Indices past the loaded vertex count read as zero and flag an error.
  assign out_of_range = ({{CNT_W{1'b0}}, cur_idx} >= {{IDX_W{1'b0}}, vcount});

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    load_exit = 1'b0;
    capture   = 1'b0;
    emitting  = 1'b0;
    handshake = 1'b0;
    next_tri  = 1'b0;
    finish    = 1'b0;
    case (state)
      LOAD: begin
        wr_en = valid_in;
        // A lone obj_done with nothing cached is ignored.
        if ((valid_in && wr_ptr == CNT_W'(NUM_VERT - 1)) ||
            (obj_done_in && (valid_in || wr_ptr != '0))) begin
          load_exit = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (lat_cnt == LAT_W'(IDX_LAT)) begin
          capture   = 1'b1;
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        emitting  = 1'b1;
        handshake = tri_ready_in;
        if (handshake && corner == 2'd2) begin
          if (last_tri) begin
            finish    = 1'b1;
            state_nxt = LOAD;
          end else begin
            next_tri  = 1'b1;
            state_nxt = FETCH;
          end
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in && wr_en) begin
      cache[wr_ptr[VA_W-1:0]] <= vert_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_ptr  <= '0;
      vcount  <= '0;
      tri_cnt <= '0;
      corner  <= '0;
      lat_cnt <= '0;
      idx     <= '0;
      err     <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + CNT_W'(1);
      end
      if (load_exit) begin
        vcount  <= wr_ptr + CNT_W'(valid_in);
        tri_cnt <= '0;
        lat_cnt <= '0;
      end
      if (state == FETCH) begin
        lat_cnt <= capture ? '0 : lat_cnt + LAT_W'(1);
      end
      if (capture) begin
        idx    <= idx_data_in;
        corner <= 2'd0;
      end
      if (handshake && corner != 2'd2) begin
        corner <= corner + 2'd1;
      end
      if (next_tri) begin
        tri_cnt <= tri_cnt + TRI_W'(1);
      end
      if (finish) begin
        wr_ptr  <= '0;
        tri_cnt <= '0;
        corner  <= '0;
      end
      if (valid_in && state != LOAD) begin
        err[0] <= 1'b1;
      end
      if (emitting && out_of_range) begin
        err[1] <= 1'b1;
      end
    end
  end

  always_comb begin
    tri_vert_out = '0;
    if (emitting && !out_of_range) begin
      tri_vert_out = cache[cur_idx[VA_W-1:0]];
    end
  end

  assign tri_valid_out  = emitting;
  assign tri_corner_out = corner;
  assign tri_last_out   = emitting && (corner == 2'd2) && last_tri;
  assign done_out       = tri_last_out && tri_ready_in;
  assign idx_addr_out   = tri_cnt;
  assign err_out        = err;

endmodule

// File: tb/tb_triangle_assembler.sv
// Bench for triangle_assembler: random objects and ROMs checked against a queue model of the emitted stream.
`timescale 1ns/1ps
module tb_triangle_assembler;
  localparam int NUM_VERT = 8;
  localparam int NUM_TRI  = 12;
  localparam int IDX_W    = 8;
  localparam int IDX_LAT  = 2;
  localparam int TRI_W    = $clog2(NUM_TRI);
  localparam logic [31:0] P = 32'h3f800000;
  localparam logic [31:0] M = 32'hbf800000;

  typedef logic [3:0][31:0] vert_t;
  typedef struct packed { vert_t vert; logic [1:0] corner; logic last; } item_t;

  logic               clk_in = 1'b0;
  logic               rst_in;
  vert_t              vert_in;
  logic               valid_in, obj_done_in;
  logic [TRI_W-1:0]   idx_addr_out;
  logic [3*IDX_W-1:0] idx_data_in;
  vert_t              tri_vert_out;
  logic [1:0]         tri_corner_out;
  logic               tri_valid_out, tri_ready_in, tri_last_out, done_out;
  logic [1:0]         err_out;

  triangle_assembler #(.NUM_VERT(NUM_VERT), .NUM_TRI(NUM_TRI), .IDX_W(IDX_W), .IDX_LAT(IDX_LAT)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .vert_in(vert_in), .valid_in(valid_in),
    .obj_done_in(obj_done_in), .idx_addr_out(idx_addr_out), .idx_data_in(idx_data_in),
    .tri_vert_out(tri_vert_out), .tri_corner_out(tri_corner_out), .tri_valid_out(tri_valid_out),
    .tri_ready_in(tri_ready_in), .tri_last_out(tri_last_out), .done_out(done_out), .err_out(err_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0, n_pass = 0;
  int accepted = 0, done_cnt = 0, last_cnt = 0;
  bit chk_en = 0;
  int ready_mode = 0;
  item_t exp_q [$];
  vert_t acc_q [$];
  vert_t cur_v [NUM_VERT];
  logic [IDX_W-1:0] rom [NUM_TRI][3];
  int cube_idx [36];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Index ROM with IDX_LAT cycles of registered read latency.
  function automatic logic [3*IDX_W-1:0] rom_word(input logic [TRI_W-1:0] a);
    if (int'(a) >= NUM_TRI) return '0;
    return {rom[a][2], rom[a][1], rom[a][0]};
  endfunction

  logic [3*IDX_W-1:0] rom_pipe [IDX_LAT];
  always @(posedge clk_in) begin
    rom_pipe[0] <= rom_word(idx_addr_out);
    for (int i = 1; i < IDX_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign idx_data_in = rom_pipe[IDX_LAT-1];

  // Reference: every triangle of the ROM, corners in order, out-of-range index reads zero.
  task automatic push_expected(input int n);
    item_t it;
    int ix;
    for (int t = 0; t < NUM_TRI; t++) begin
      for (int c = 0; c < 3; c++) begin
        ix = int'(rom[t][c]);
        it.vert = (ix < n) ? cur_v[ix] : '0;
        it.corner = 2'(c);
        it.last = (t == NUM_TRI - 1) && (c == 2);
        exp_q.push_back(it);
      end
    end
  endtask

  item_t e_cur;
  bit prev_stall = 0;
  logic [1:0] prev_c;
  vert_t prev_v;
  always @(negedge clk_in) begin
    if (!rst_in || !chk_en) begin
      prev_stall = 0;
    end else begin
      if (prev_stall)
        chk("stall_stable", {tri_valid_out, tri_corner_out, tri_vert_out}, {1'b1, prev_c, prev_v});
      if (tri_valid_out) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_vertex", tri_valid_out, 0);
        end else begin
          e_cur = exp_q[0];
          chk("vert", tri_vert_out, e_cur.vert);
          chk("corner", tri_corner_out, e_cur.corner);
          chk("last", tri_last_out, e_cur.last);
          chk("done", done_out, e_cur.last && tri_ready_in);
          if (tri_ready_in) begin
            void'(exp_q.pop_front());
            acc_q.push_back(tri_vert_out);
            accepted++;
            if (done_out) done_cnt++;
            if (tri_last_out) last_cnt++;
          end
        end
      end else begin
        chk("idle_flags", {done_out, tri_last_out}, 0);
      end
      prev_stall = tri_valid_out && !tri_ready_in;
      prev_c = tri_corner_out;
      prev_v = tri_vert_out;
    end
  end

  initial begin
    tri_ready_in = 1'b1;
    forever begin
      @(posedge clk_in); #1;
      tri_ready_in = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  function automatic vert_t cube_v(input int k);
    return {k[2] ? P : M, k[1] ? P : M, k[0] ? P : M, P};
  endfunction

  task automatic rand_rom(input int lim);
    for (int t = 0; t < NUM_TRI; t++)
      for (int c = 0; c < 3; c++) rom[t][c] = IDX_W'($urandom_range(0, lim - 1));
  endtask

  task automatic rand_verts();
    for (int i = 0; i < NUM_VERT; i++) cur_v[i] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic cube_setup();
    cube_idx = '{0,1,2, 0,2,3, 4,6,5, 4,7,6, 0,4,5, 0,5,1, 1,5,6, 1,6,2, 2,6,7, 2,7,3, 3,7,4, 3,4,0};
    for (int t = 0; t < NUM_TRI; t++)
      for (int c = 0; c < 3; c++) rom[t][c] = IDX_W'(cube_idx[t*3+c]);
    for (int k = 0; k < NUM_VERT; k++) cur_v[k] = cube_v(k);
  endtask

  task automatic send_obj(input int n, input bit done_with_last, input bit gaps);
    int g;
    for (int i = 0; i < n; i++) begin
      g = (gaps && i > 0) ? $urandom_range(0, 2) : 0;
      repeat (g) begin
        valid_in = 0; obj_done_in = 0;
        @(posedge clk_in); #1;
      end
      valid_in = 1; vert_in = cur_v[i];
      obj_done_in = done_with_last && (i == n - 1);
      @(posedge clk_in); #1;
    end
    valid_in = 0; obj_done_in = 0;
    if (!done_with_last && n < NUM_VERT) begin
      obj_done_in = 1;
      @(posedge clk_in); #1;
      obj_done_in = 0;
    end
  endtask

  task automatic wait_done(input int budget, output int first_cyc, output int done_cyc);
    bit seen;
    seen = 0; first_cyc = -1; done_cyc = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk_in);
      if (tri_valid_out && first_cyc < 0) first_cyc = i;
      if (done_out) begin seen = 1; done_cyc = i; end
    end
    chk("done_seen", seen, 1);
    @(posedge clk_in); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, dbase, lbase, f, d;
    bit hit;
    rst_in = 0; valid_in = 0; obj_done_in = 0; vert_in = '0;
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_valid", tri_valid_out, 0);
    chk("rst_flags", {tri_last_out, done_out, err_out}, 0);
    chk("rst_addr_corner", {idx_addr_out, tri_corner_out}, 0);
    chk("rst_vert", tri_vert_out, 0);
    rst_in = 1; chk_en = 1;

    // Cube with ready held high: content, counts and minimum cycle cost.
    ready_mode = 0; cube_setup();
    base = accepted; dbase = done_cnt; lbase = last_cnt;
    push_expected(8); send_obj(8, 0, 0);
    wait_done(400, f, d);
    chk("cube_count", accepted - base, 36);
    chk("cube_done_once", done_cnt - dbase, 1);
    chk("cube_last_once", last_cnt - lbase, 1);
    chk("cube_acc4_v2", acc_q[base+4], 128'hbf800000_3f800000_bf800000_3f800000);
    chk("cube_acc35_v0", acc_q[base+35], 128'hbf800000_bf800000_bf800000_3f800000);
    chk("cube_min_cycles", d - f, (NUM_TRI - 1) * (IDX_LAT + 4) + 2);
    chk("cube_err", err_out, 0);

    // Cube again under random backpressure.
    ready_mode = 1; cube_setup();
    base = accepted; dbase = done_cnt;
    push_expected(8); send_obj(8, 0, 1);
    wait_done(3000, f, d);
    chk("bp_count", accepted - base, 36);
    chk("bp_done_once", done_cnt - dbase, 1);
    chk("bp_err", err_out, 0);

    // Back-to-back: the second object starts the cycle after done_out.
    rand_rom(8); rand_verts();
    base = accepted;
    push_expected(8); send_obj(8, 1, 1);
    wait_done(3000, f, d);
    rand_rom(5); rand_verts();
    push_expected(5); send_obj(5, 1, 0);
    wait_done(3000, f, d);
    chk("b2b_count", accepted - base, 72);
    chk("b2b_err", err_out, 0);

    // Overflow: vertices pushed while emitting are dropped.
    rand_rom(8); rand_verts();
    base = accepted;
    push_expected(8); send_obj(8, 0, 1);
    for (int k = 0; k < 3; k++) begin
      hit = 0;
      for (int c = 0; c < 300 && !hit; c++) begin
        @(posedge clk_in); #1;
        if (tri_valid_out && (accepted - base) < 20) hit = 1;
      end
      chk("ovf_window", hit, 1);
      if (hit) begin
        valid_in = 1; vert_in = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk_in); #1;
        valid_in = 0;
      end
      repeat (4) @(posedge clk_in);
      #1;
    end
    wait_done(3000, f, d);
    chk("ovf_count", accepted - base, 36);
    chk("ovf_err", err_out, 2'b01);

    // Short object: lone obj_done ignored, then 3 vertices with index 5 in triangle 0.
    ready_mode = 0;
    obj_done_in = 1;
    @(posedge clk_in); #1;
    obj_done_in = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_in); #1;
      chk("empty_done_ignored", tri_valid_out, 0);
    end
    rand_rom(3); rom[0][1] = 8'd5; rand_verts();
    base = accepted;
    push_expected(3); send_obj(3, 1, 0);
    wait_done(400, f, d);
    chk("short_count", accepted - base, 36);
    chk("short_zero_corner", acc_q[base+1], 0);
    chk("short_err", err_out, 2'b11);

    // Reset in the middle of triangle 4, then reload.
    rand_rom(8); rand_verts();
    base = accepted;
    push_expected(8); send_obj(8, 0, 0);
    hit = 0;
    for (int c = 0; c < 400 && !hit; c++) begin
      @(posedge clk_in); #1;
      if (accepted - base >= 13) hit = 1;
    end
    chk("mid_emit_reached", {hit, tri_valid_out, tri_corner_out}, {1'b1, 1'b1, 2'd1});
    rst_in = 0;
    @(posedge clk_in); #1;
    chk("abort_valid", tri_valid_out, 0);
    chk("abort_flags", {tri_last_out, done_out, err_out}, 0);
    chk("abort_addr_corner", {idx_addr_out, tri_corner_out}, 0);
    chk("abort_vert", tri_vert_out, 0);
    exp_q.delete();
    rst_in = 1;
    rand_rom(6); rand_verts();
    base = accepted;
    push_expected(6); send_obj(6, 0, 1);
    wait_done(400, f, d);
    chk("reload_count", accepted - base, 36);
    chk("reload_err", err_out, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/triangle_assembler.md
TRIANGLE_ASSEMBLER -- requirements
Module: triangle_assembler

Interface
REQ-001 Parameter NUM_VERT, default 8, is the vertex cache depth (max vertices per object).
REQ-002 Parameter NUM_TRI, default 12, is the number of triangles emitted per object.
REQ-003 Parameter IDX_W, default 8, is the width of one vertex index.
REQ-004 Parameter IDX_LAT, default 2, is the index-ROM read latency in cycles.
REQ-005 clk_in  input  1  sole clock; all logic on rising edge.
REQ-006 rst_in  input  1  reset, synchronous, active-low.
REQ-007 vert_in  input  [3:0][31:0]  transformed vertex, float32; [0]=w, [1..3]=coordinates.
REQ-008 valid_in  input  1  vert_in valid this cycle; no backpressure upstream.
REQ-009 obj_done_in  input  1  object ends with the vertex qualified in the same or an earlier cycle.
REQ-010 idx_addr_out  output  $clog2(NUM_TRI)  triangle number presented to the index ROM.
REQ-011 idx_data_in  input  3*IDX_W  {i2,i1,i0}; i0 in the LSBs.
REQ-012 tri_vert_out  output  [3:0][31:0]  emitted vertex.
REQ-013 tri_corner_out  output  2  corner number 0..2 of tri_vert_out.
REQ-014 tri_valid_out  output  1  tri_vert_out valid.
REQ-015 tri_ready_in  input  1  downstream accepts when tri_valid_out && tri_ready_in.
REQ-016 tri_last_out  output  1  high with corner 2 of triangle NUM_TRI-1.
REQ-017 done_out  output  1  one-cycle pulse when the final vertex is accepted.
REQ-018 err_out  output  2  sticky; [0]=input overflow, [1]=index out of range.

Function
REQ-019 State machine states: LOAD, FETCH, EMIT.
REQ-020 LOAD: each valid_in writes vert_in to cache[wr_ptr] and increments wr_ptr.
REQ-021 LOAD exits to FETCH, with tri_cnt=0 and vcount=number of vertices written, when a write fills entry NUM_VERT-1 or when obj_done_in is high.
REQ-022 Precedence in LOAD: valid_in and obj_done_in in the same cycle write the vertex first, then exit.
REQ-023 obj_done_in with zero vertices loaded is ignored; the block stays in LOAD.
REQ-024 valid_in outside LOAD drops the vertex and sets err_out[0].
REQ-025 FETCH: idx_addr_out=tri_cnt for IDX_LAT cycles, then idx_data_in is captured into i0/i1/i2 and the state moves to EMIT with corner=0.
REQ-026 EMIT: tri_vert_out=cache[i_corner] and tri_corner_out=corner, with tri_valid_out high.
REQ-027 EMIT: if i_corner >= vcount, tri_vert_out is all zeros and err_out[1] is set.
REQ-028 EMIT: outputs hold stable while tri_valid_out && !tri_ready_in.
REQ-029 EMIT: a handshake on corners 0 or 1 advances corner; the next vertex is presented the following cycle with no bubble.
REQ-030 EMIT: a handshake on corner 2 with tri_cnt<NUM_TRI-1 increments tri_cnt, goes to FETCH, and drops tri_valid_out.
REQ-031 EMIT: a handshake on corner 2 with tri_cnt=NUM_TRI-1 pulses done_out, clears wr_ptr, and returns to LOAD.
REQ-032 Minimum cost per triangle is IDX_LAT+1+3 cycles with tri_ready_in held high.
REQ-033 Only err_out is sticky; it clears on reset only.

Reset
REQ-034 While rst_in is low at a clock edge: state goes to LOAD, and wr_ptr, vcount, tri_cnt, corner and all outputs go to 0, including err_out.
REQ-035 Reset mid-EMIT or mid-FETCH aborts the object, and tri_valid_out is low after that edge.
REQ-036 Cache contents are not reset.

Verification
REQ-037 Cube: 8 vertices, cube index ROM, ready always high -> 36 vertices in 12 groups of corners 0,1,2; tri_last_out on the 36th; done_out once; err_out=0.
REQ-038 Backpressure: ready toggled randomly -> same 36-vertex sequence; outputs stable while stalled; no loss or duplication.
REQ-039 Short object: 3 vertices then obj_done_in, ROM index 5 in triangle 0 -> that corner is zeros; err_out[1]=1.
REQ-040 Overflow: valid_in pulsed during EMIT -> err_out[0]=1; emitted data unchanged.
REQ-041 Reset asserted mid-EMIT of triangle 4 -> tri_valid_out=0 next cycle; a reloaded object emits from triangle 0.
REQ-042 Back-to-back: two objects, second starting the cycle after done_out -> both emit correctly; the second uses only new vertices.
